// File: rtl/fetch_sequencer.sv
// Polaris instruction-fetch sequencer: one bus read at a time, with a
// single-entry instruction holding register offered to decode.
module fetch_sequencer #(
    parameter logic [63:0] RESET_PC = 64'hFFFF_FFFF_FFFF_FF00
) (
    input  logic        clk_i,
    input  logic        reset_i,
    output logic [63:0] iadr_o,
    output logic        istb_o,
    input  logic        iack_i,
    input  logic [31:0] idat_i,
    output logic [31:0] inst_o,
    output logic [63:0] ip_o,
    output logic        inst_valid_o,
    input  logic        inst_ready_i,
    input  logic        pc_we_i,
    input  logic [63:0] pc_i,
    input  logic        pipe_empty_i
);

    localparam logic [31:0] NOP      = 32'h0000_0013;
    localparam logic [6:0]  OP_FENCE = 7'b0001111;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DRAIN,
        HOLD
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [63:0] r_pc;
    logic [63:0] r_ip;
    logic [31:0] r_ir;
    logic [63:0] w_pc_nxt;
    logic [63:0] w_ip_nxt;
    logic [31:0] w_ir_nxt;
    logic [63:0] w_target;
    logic        w_fence;
    logic        w_valid;

    assign w_target = pc_i & ~64'h3;
    assign w_fence  = (r_ir[6:0] == OP_FENCE);
    // A held FENCE is only offered once everything older has retired.
    assign w_valid  = (r_state == HOLD) && (!w_fence || pipe_empty_i);

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_ip_nxt    = r_ip;
        w_ir_nxt    = r_ir;
        unique case (r_state)
            IDLE: begin
                w_state_nxt = FETCH;
                if (pc_we_i) w_pc_nxt = w_target;
            end
            FETCH: begin
                if (pc_we_i) begin
                    w_pc_nxt    = w_target;
                    w_state_nxt = iack_i ? FETCH : DRAIN;
                end else if (iack_i) begin
                    w_ir_nxt    = idat_i;
                    w_ip_nxt    = r_pc;
                    w_pc_nxt    = r_pc + 64'd4;
                    w_state_nxt = HOLD;
                end
            end
            DRAIN: begin
                // The ack of the abandoned cycle carries the old word.
                if (pc_we_i) w_pc_nxt = w_target;
                if (iack_i) w_state_nxt = FETCH;
            end
            HOLD: begin
                if (pc_we_i) begin
                    w_pc_nxt    = w_target;
                    w_state_nxt = FETCH;
                end else if (w_valid && inst_ready_i) begin
                    w_state_nxt = FETCH;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state <= IDLE;
            r_pc    <= RESET_PC;
            r_ip    <= RESET_PC;
            r_ir    <= NOP;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_ip    <= w_ip_nxt;
            r_ir    <= w_ir_nxt;
        end
    end

    assign iadr_o       = r_pc;
    assign istb_o       = (r_state == FETCH) || (r_state == DRAIN);
    assign inst_o       = r_ir;
    assign ip_o         = r_ip;
    assign inst_valid_o = w_valid;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed scenarios plus random traffic checked
// against an architectural model of the expected instruction stream.
module tb_fetch_sequencer;

    localparam logic [63:0] RPC = 64'hFFFF_FFFF_FFFF_FF00;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] iadr;
    logic        istb;
    logic        iack;
    logic [31:0] idat;
    logic [31:0] inst;
    logic [63:0] ip;
    logic        valid;
    logic        ready;
    logic        pc_we;
    logic [63:0] pc_tgt;
    logic        pe;

    always #5 clk = ~clk;

    fetch_sequencer dut (
        .clk_i        (clk),
        .reset_i      (rst),
        .iadr_o       (iadr),
        .istb_o       (istb),
        .iack_i       (iack),
        .idat_i       (idat),
        .inst_o       (inst),
        .ip_o         (ip),
        .inst_valid_o (valid),
        .inst_ready_i (ready),
        .pc_we_i      (pc_we),
        .pc_i         (pc_tgt),
        .pipe_empty_i (pe)
    );

    int          n_chk = 0;
    int          n_fail = 0;
    logic [31:0] mem_ovr [logic [63:0]];
    bit          fence_en = 0;
    bit          ws_rand = 0;
    bit          stray = 0;
    int          ws = 0;
    bit          busy = 0;
    logic [63:0] lat = '0;
    int          left = 0;
    logic [63:0] exp_ip = RPC;
    int          idle = 0;

    // Instruction memory: explicit words, else a hashed non-FENCE word.
    function automatic logic [31:0] memw(input logic [63:0] a);
        logic [31:0] h;
        if (mem_ovr.exists(a)) return mem_ovr[a];
        if (fence_en && a[6:2] == 5'h1F) return 32'h0000_000F;
        h = (a[31:0] * 32'h9E37_79B1) ^ a[63:32];
        return {h[31:7], 7'b0010011};
    endfunction

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Bus slave: latches the address when a cycle starts, acks after waits.
    task automatic slave_eval();
        if (!istb) begin
            busy = 0;
            iack = stray;
            idat = 32'h0;
        end else begin
            if (!busy) begin
                busy = 1;
                lat  = iadr;
                left = ws_rand ? int'($urandom_range(0, 3)) : ws;
            end
            if (left == 0) begin
                iack = 1'b1;
                idat = memw(lat);
                busy = 0;
            end else begin
                iack = 1'b0;
                idat = $urandom;
                left--;
            end
        end
    endtask

    // One clock: slave response, model update and checks, then the edge.
    task automatic step();
        bit acc;
        slave_eval();
        #2;
        acc = 0;
        if (rst) begin
            exp_ip = RPC;
        end else begin
            if (valid) begin
                chk("hold_no_stb", istb, 0);
                if (inst[6:0] == 7'b0001111) chk("fence_gate", pe, 1);
            end
            if (istb) chk("iadr_align", iadr[1:0], 0);
            if (pc_we) begin
                exp_ip = pc_tgt & ~64'h3;
            end else if (valid && ready) begin
                chk("acc_ip", ip, exp_ip);
                chk("acc_inst", inst, memw(exp_ip));
                exp_ip += 64'd4;
                acc = 1;
            end
        end
        idle = (acc || pc_we || rst) ? 0 : idle + 1;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (!valid && n < 20) begin
            step();
            n++;
        end
        chk(tag, valid, 1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int cyc;
        int last;
        int k;
        rst    = 1'b1;
        iack   = 1'b0;
        idat   = '0;
        ready  = 1'b0;
        pc_we  = 1'b0;
        pc_tgt = '0;
        pe     = 1'b1;
        @(posedge clk);
        #1;
        step();
        chk("rst_stb", istb, 0);
        chk("rst_valid", valid, 0);
        chk("rst_iadr", iadr, RPC);
        chk("rst_ip", ip, RPC);
        chk("rst_inst", inst, 32'h13);

        // Zero-wait fetch of LUI then NOP
        mem_ovr[RPC]      = 32'hAAAA_ADB7;
        mem_ovr[RPC + 4]  = 32'h0000_0013;
        ws  = 0;
        rst = 1'b0;
        step();
        chk("t1_stb", istb, 1);
        chk("t1_iadr0", iadr, RPC);
        step();
        chk("t1_valid", valid, 1);
        chk("t1_inst", inst, 32'hAAAA_ADB7);
        chk("t1_ip", ip, RPC);
        chk("t1_hold_stb", istb, 0);
        step();
        chk("t1_stall_valid", valid, 1);
        chk("t1_stall_stb", istb, 0);
        ready = 1'b1;
        step();
        ready = 1'b0;
        chk("t1_iadr1", iadr, RPC + 4);
        chk("t1_stb1", istb, 1);
        step();
        chk("t1_valid1", valid, 1);
        chk("t1_ip1", ip, RPC + 4);
        chk("t1_inst1", inst, 32'h13);
        ready = 1'b1;
        step();

        // Three wait states, decode always ready
        do_reset();
        ws    = 3;
        ready = 1'b1;
        cyc   = 0;
        last  = 0;
        k     = 0;
        while (k < 3 && cyc < 40) begin
            if (valid) begin
                chk("w3_ip", ip, RPC + 64'(4 * k));
                if (k > 0) chk("w3_period", 64'(cyc - last), 5);
                last = cyc;
                k++;
            end else if (cyc > 0) begin
                chk("w3_stb", istb, 1);
            end
            step();
            cyc++;
        end
        chk("w3_count", 64'(k), 3);

        // Redirect while holding, with ready high
        ws    = 0;
        ready = 1'b0;
        wait_valid("t3_wait");
        pc_we  = 1'b1;
        pc_tgt = 64'h1003;
        ready  = 1'b1;
        step();
        pc_we = 1'b0;
        ready = 1'b0;
        chk("t3_drop", valid, 0);
        chk("t3_iadr", iadr, 64'h1000);
        chk("t3_stb", istb, 1);
        step();
        chk("t3_valid", valid, 1);
        chk("t3_ip", ip, 64'h1000);
        ready = 1'b1;
        step();
        ready = 1'b0;

        // Redirect in FETCH ahead of a delayed ack
        ws = 2;
        mem_ovr[64'h1004] = 32'hDEAD_BEEF;
        pc_we  = 1'b1;
        pc_tgt = 64'h2000;
        step();
        pc_we = 1'b0;
        chk("t4_stb", istb, 1);
        chk("t4_iadr", iadr, 64'h2000);
        chk("t4_valid", valid, 0);
        step();
        chk("t4_drain_stb", istb, 1);
        step();
        chk("t4_discard", valid, 0);
        chk("t4_refetch", iadr, 64'h2000);
        wait_valid("t4_wait");
        chk("t4_ip", ip, 64'h2000);
        chk("t4_inst", inst, memw(64'h2000));
        ready = 1'b1;
        step();
        ready = 1'b0;

        // FENCE held until the pipe drains
        ws = 0;
        mem_ovr[64'h2004] = 32'h0000_000F;
        pe    = 1'b0;
        ready = 1'b1;
        step();
        for (int i = 0; i < 6; i++) begin
            chk("t5_fence_wait", valid, 0);
            chk("t5_no_stb", istb, 0);
            step();
        end
        pe = 1'b1;
        #1;
        chk("t5_release", valid, 1);
        chk("t5_inst", inst, 32'h0000_000F);
        step();
        ready = 1'b0;

        // Redirect with same-cycle ack, then wrap past the top
        pc_we  = 1'b1;
        pc_tgt = 64'hFFFF_FFFF_FFFF_FFFE;
        step();
        pc_we = 1'b0;
        chk("t6_iadr", iadr, 64'hFFFF_FFFF_FFFF_FFFC);
        chk("t6_stb", istb, 1);
        step();
        chk("t6_ip", ip, 64'hFFFF_FFFF_FFFF_FFFC);
        ready = 1'b1;
        step();
        ready = 1'b0;
        chk("t6_wrap", iadr, 64'h0);

        // Reset during DRAIN, then a stray ack in IDLE
        ws     = 3;
        pc_we  = 1'b1;
        pc_tgt = 64'h3000;
        step();
        pc_we = 1'b0;
        chk("t7_drain_stb", istb, 1);
        chk("t7_iadr", iadr, 64'h3000);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t7_rst_stb", istb, 0);
        chk("t7_rst_iadr", iadr, RPC);
        chk("t7_rst_valid", valid, 0);
        chk("t7_rst_ip", ip, RPC);
        chk("t7_rst_inst", inst, 32'h13);
        stray = 1;
        step();
        stray = 0;
        chk("t7_stray_stb", istb, 1);
        chk("t7_stray_iadr", iadr, RPC);
        chk("t7_stray_valid", valid, 0);
        ws = 0;
        wait_valid("t7_wait");
        chk("t7_ip", ip, RPC);
        chk("t7_inst", inst, 32'hAAAA_ADB7);

        // Random traffic
        fence_en = 1;
        ws_rand  = 1;
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            ready = ($urandom_range(0, 9) < 7);
            pe    = ($urandom_range(0, 9) < 7);
            pc_we = ($urandom_range(0, 11) == 0);
            case ($urandom_range(0, 2))
                0:       pc_tgt = {$urandom, $urandom};
                1:       pc_tgt = 64'hFFFF_FFFF_FFFF_FFF0 |
                                  64'($urandom_range(0, 15));
                default: pc_tgt = 64'($urandom_range(0, 255));
            endcase
            rst = ($urandom_range(0, 399) == 0);
            step();
            if (idle > 60) begin
                chk("progress", 64'(idle), 0);
                idle = 0;
            end
        end
        rst   = 1'b0;
        pc_we = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
